// File: rtl/clockmon_mc.sv
// clockmon_mc: multi-channel clock presence, frequency (edges per gate window) and range monitor.
module clockmon_mc #(
    parameter int CHANNELS = 4,
    parameter int GATE     = 1024,
    parameter int TIMEOUT  = 16,
    parameter int CNTWIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          mon_tgl,
    input  logic [CNTWIDTH-1:0]          lo_limit,
    input  logic [CNTWIDTH-1:0]          hi_limit,
    output logic [CHANNELS-1:0]          detected,
    output logic [CHANNELS-1:0]          inrange,
    output logic [CHANNELS*CNTWIDTH-1:0] freq_cnt,
    output logic                         freq_valid
);
    localparam int GW = $clog2(GATE);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [GW-1:0] GLAST = GW'(GATE - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [GW-1:0]                       gcnt_q, gcnt_d;
    logic                                wend;
    logic                                fv_q, fv_d;
    logic [CHANNELS-1:0][2:0]            s_q, s_d;
    logic [CHANNELS-1:0]                 e_q, e_d;
    logic [CHANNELS-1:0]                 det_q, det_d;
    logic [CHANNELS-1:0]                 inr_q, inr_d;
    logic [CHANNELS-1:0][TW-1:0]         tcnt_q, tcnt_d;
    logic [CHANNELS-1:0][CNTWIDTH-1:0]   acc_q, acc_d;
    logic [CHANNELS-1:0][CNTWIDTH-1:0]   fcnt_q, fcnt_d;

    always_comb begin
        wend   = gcnt_q == GLAST;
        gcnt_d = wend ? '0 : gcnt_q + GW'(1);
        fv_d   = wend;
        s_d    = s_q;
        e_d    = e_q;
        det_d  = det_q;
        inr_d  = inr_q;
        tcnt_d = tcnt_q;
        acc_d  = acc_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            s_d[i]    = {s_q[i][1:0], mon_tgl[i]};
            e_d[i]    = s_q[i][1] ^ s_q[i][2];
            tcnt_d[i] = e_q[i] ? '0 : (tcnt_q[i] == TLAST) ? TLAST : tcnt_q[i] + TW'(1);
            det_d[i]  = tcnt_q[i] != TLAST;
            // an edge seen on the window-end cycle seeds the next window
            acc_d[i]  = wend ? CNTWIDTH'(e_q[i]) :
                        (&acc_q[i]) ? acc_q[i] : acc_q[i] + CNTWIDTH'(e_q[i]);
            fcnt_d[i] = wend ? acc_q[i] : fcnt_q[i];
            inr_d[i]  = det_q[i] && (wend ? (acc_q[i] >= lo_limit && acc_q[i] <= hi_limit) : inr_q[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gcnt_q <= '0;
            fv_q   <= 1'b0;
            s_q    <= '0;
            e_q    <= '0;
            det_q  <= '0;
            inr_q  <= '0;
            tcnt_q <= {CHANNELS{TLAST}};
            acc_q  <= '0;
            fcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
            fv_q   <= fv_d;
            s_q    <= s_d;
            e_q    <= e_d;
            det_q  <= det_d;
            inr_q  <= inr_d;
            tcnt_q <= tcnt_d;
            acc_q  <= acc_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign detected   = det_q;
    assign inrange    = inr_q;
    assign freq_cnt   = fcnt_q;
    assign freq_valid = fv_q;
endmodule

// File: tb/tb_clockmon_mc.sv
// tb_clockmon_mc: two monitors (16-bit and saturating 4-bit counts) driven by shared toggles,
// checked every cycle against a toggle-timestamp reference model.
module tb_clockmon_mc;
    localparam int G  = 64;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mon_tgl;
    logic [15:0] loA, hiA;
    logic [3:0]  loB, hiB;
    logic [3:0]  detA, inrA, detB, inrB;
    logic [63:0] fcA;
    logic [15:0] fcB;
    logic        fvA, fvB;

    clockmon_mc #(.CHANNELS(4), .GATE(G), .TIMEOUT(TO), .CNTWIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .mon_tgl(mon_tgl), .lo_limit(loA), .hi_limit(hiA),
        .detected(detA), .inrange(inrA), .freq_cnt(fcA), .freq_valid(fvA));
    clockmon_mc #(.CHANNELS(4), .GATE(G), .TIMEOUT(TO), .CNTWIDTH(4)) dut_b (
        .clk(clk), .reset(reset), .mon_tgl(mon_tgl), .lo_limit(loB), .hi_limit(hiB),
        .detected(detB), .inrange(inrB), .freq_cnt(fcB), .freq_valid(fvB));

    always #5 clk = ~clk;

    typedef struct {
        int p0, p1, p2, p3;
        int lo_a, hi_a, x_a;
        bit i_a;
        int lo_b, hi_b, x_b;
        bit i_b;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int tq[4][$];
    int per[4], base[4], lastm[4];
    int xfA[4], xfB[4];
    bit [3:0] xiA, xiB;

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", nm, n, got, exp);
        end
    endtask

    // A toggle driven after edge m is consumed by the counters at edge m+4.
    function automatic int wcount(int c, int j);
        int cnt = 0;
        for (int k = 0; k < tq[c].size(); k++)
            if (tq[c][k] + 4 >= (j - 1) * G && tq[c][k] + 4 <= j * G - 1) cnt++;
        return cnt;
    endfunction

    function automatic bit mdet(int c, int t);
        for (int k = 0; k < tq[c].size(); k++)
            if (t >= tq[c][k] + 5 && t <= tq[c][k] + TO + 3) return 1'b1;
        return 1'b0;
    endfunction

    task automatic tgl(input int c);
        mon_tgl[c] = ~mon_tgl[c];
        tq[c].push_back(n);
        lastm[c] = n;
    endtask

    task automatic check();
        bit w;
        int cnt;
        logic [3:0] xd;
        logic [63:0] eA;
        logic [15:0] eB;
        w = (n % G) == 0;
        for (int c = 0; c < 4; c++) begin
            xd[c] = mdet(c, n);
            if (w) begin
                cnt = wcount(c, n / G);
                xfA[c] = cnt > 65535 ? 65535 : cnt;
                xfB[c] = cnt > 15 ? 15 : cnt;
            end
            if (!mdet(c, n - 1)) begin
                xiA[c] = 1'b0;
                xiB[c] = 1'b0;
            end else if (w) begin
                xiA[c] = int'(loA) <= xfA[c] && xfA[c] <= int'(hiA);
                xiB[c] = int'(loB) <= xfB[c] && xfB[c] <= int'(hiB);
            end
            eA[c*16 +: 16] = 16'(xfA[c]);
            eB[c*4 +: 4]   = 4'(xfB[c]);
        end
        cmp("valid_a", fvA, w);
        cmp("valid_b", fvB, w);
        cmp("det_a", detA, xd);
        cmp("det_b", detB, xd);
        cmp("inr_a", inrA, xiA);
        cmp("inr_b", inrB, xiB);
        cmp("cnt_a", fcA, eA);
        cmp("cnt_b", fcB, eB);
    endtask

    task automatic drive();
        for (int c = 0; c < 4; c++) begin
            if (per[c] >= 2 && ((n - base[c]) % per[c]) == 0) tgl(c);
            else if (per[c] == 1 && n - lastm[c] >= 2 && $urandom_range(0, 2) == 0) tgl(c);
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        @(negedge clk);
        for (int c = 0; c < 4; c++)
            while (tq[c].size() > 0 && tq[c][0] < n - 2 * G - 10) void'(tq[c].pop_front());
        check();
        drive();
    endtask

    task automatic setp(input int a, input int b, input int c, input int d);
        per[0] = a; per[1] = b; per[2] = c; per[3] = d;
        for (int k = 0; k < 4; k++) base[k] = n;
    endtask

    task automatic zero_outs(input string nm);
        cmp({nm, "_det_a"}, detA, 0);
        cmp({nm, "_inr_a"}, inrA, 0);
        cmp({nm, "_cnt_a"}, fcA, 0);
        cmp({nm, "_val_a"}, fvA, 0);
        cmp({nm, "_det_b"}, detB, 0);
        cmp({nm, "_inr_b"}, inrB, 0);
        cmp({nm, "_cnt_b"}, fcB, 0);
        cmp({nm, "_val_b"}, fvB, 0);
    endtask

    // Synchronizer stages reset to 0, so a high toggle level at release reads as an edge after edge 0.
    task automatic do_release();
        reset = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            tq[c].delete();
            lastm[c] = -10;
            base[c] = 0;
            xfA[c] = 0;
            xfB[c] = 0;
            if (mon_tgl[c]) begin
                tq[c].push_back(0);
                lastm[c] = 0;
            end
        end
        xiA = '0;
        xiB = '0;
    endtask

    vec_t tbl[5];

    initial begin
        int nf, mlast, fvn;
        tbl[0] = '{4, 3, 5, 0, 15, 17, 16, 1'b1, 10, 15, 15, 1'b1};
        tbl[1] = '{2, 5, 8, 3, 0, 31, 32, 1'b0, 15, 15, 15, 1'b1};
        tbl[2] = '{8, 8, 0, 5, 9, 8, 8, 1'b0, 8, 8, 8, 1'b1};
        tbl[3] = '{16, 4, 3, 0, 4, 4, 4, 1'b1, 5, 15, 4, 1'b0};
        tbl[4] = '{0, 2, 4, 8, 0, 0, 0, 1'b0, 0, 15, 0, 1'b0};
        reset = 1'b1;
        mon_tgl = '0;
        loA = 0; hiA = 0; loB = 0; hiB = 0;
        setp(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mon_tgl = mon_tgl ^ 4'(k + 5);
            #1 zero_outs("in_reset");
        end
        @(negedge clk);
        do_release();
        repeat (2 * G) step();

        for (int t = 0; t < 5; t++) begin
            while ((n % G) != 0) step();
            setp(tbl[t].p0, tbl[t].p1, tbl[t].p2, tbl[t].p3);
            loA = 16'(tbl[t].lo_a); hiA = 16'(tbl[t].hi_a);
            loB = 4'(tbl[t].lo_b);  hiB = 4'(tbl[t].hi_b);
            repeat (3 * G) step();
            cmp($sformatf("tbl%0d_cnt_a0", t), fcA[15:0], 64'(tbl[t].x_a));
            cmp($sformatf("tbl%0d_inr_a0", t), inrA[0], 64'(tbl[t].i_a));
            cmp($sformatf("tbl%0d_cnt_b0", t), fcB[3:0], 64'(tbl[t].x_b));
            cmp($sformatf("tbl%0d_inr_b0", t), inrB[0], 64'(tbl[t].i_b));
        end

        // clock loss mid-window: detected drops, inrange follows one cycle later
        while ((n % G) != 0) step();
        setp(4, 0, 0, 0);
        loA = 15; hiA = 17;
        repeat (2 * G + 10) step();
        cmp("loss_pre_inr", inrA[0], 1);
        per[0] = 0;
        mlast = lastm[0];
        nf = -1;
        for (int k = 0; k < 40 && nf < 0; k++) begin
            step();
            if (!detA[0]) nf = n;
        end
        cmp("loss_seen", nf >= 0, 1);
        cmp("loss_delay", (nf - mlast) >= 17 && (nf - mlast) <= 20, 1);
        cmp("loss_inr_hold", inrA[0], 1);
        step();
        cmp("loss_inr_drop", inrA[0], 0);
        cmp("loss_no_wend", fvA, 0);

        // single edge landing on the window-end cycle
        setp(0, 0, 0, 0);
        repeat (G) step();
        while ((n % G) != G - 4) step();
        tgl(0);
        while ((n % G) != 0) step();
        cmp("wend_edge_first", fcA[15:0], 0);
        repeat (G) step();
        cmp("wend_edge_next_a", fcA[15:0], 1);
        cmp("wend_edge_next_b", fcB[3:0], 1);

        // reset mid-window with channels at different rates
        setp(3, 5, 8, 0);
        repeat (G) step();
        while ((n % G) != 30) step();
        reset = 1'b1;
        #1 zero_outs("mid_reset");
        repeat (3) @(negedge clk);
        do_release();
        fvn = -1;
        for (int k = 0; k < 2 * G; k++) begin
            step();
            if (fvA && fvn < 0) fvn = n;
        end
        cmp("post_reset_valid", fvn, G);

        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 4; c++) begin
                per[c] = $urandom_range(0, 12);
                base[c] = n;
            end
            loA = 16'($urandom_range(0, 40)); hiA = 16'($urandom_range(0, 40));
            loB = 4'($urandom_range(0, 15));  hiB = 4'($urandom_range(0, 15));
            repeat ($urandom_range(40, 200)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
